// File: rtl/stepdown_gate_seq.sv
// Non-overlap gate sequencer for the stepdown core: dead-time insertion,
// leading-edge blanking of the overcurrent comparator and fault auto-retry.
module stepdown_gate_seq #(
  parameter int DEAD_W  = 4,
  parameter int BLANK_W = 4,
  parameter int RETRY_W = 8
) (
  input  logic               CELCLK,
  input  logic               CELRSTN,
  input  logic               CELV,
  input  logic               CELG,
  input  logic               SUB,
  input  logic               en,
  input  logic               pwm,
  input  logic               ocp,
  input  logic [DEAD_W-1:0]  dead,
  input  logic [BLANK_W-1:0] blank,
  input  logic [RETRY_W-1:0] retry,
  output logic               hs,
  output logic               ls,
  output logic               fault,
  output logic [2:0]         state,
  output logic [7:0]         fault_cnt
);

  localparam int MAX_DB = (DEAD_W > BLANK_W) ? DEAD_W : BLANK_W;
  localparam int CNT_W  = (MAX_DB > RETRY_W) ? MAX_DB : RETRY_W;

  typedef enum logic [2:0] {
    S_OFF      = 3'd0,
    S_DT_TO_HS = 3'd1,
    S_HS_ON    = 3'd2,
    S_DT_TO_LS = 3'd3,
    S_LS_ON    = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  state_t           cur;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] dead_eff;
  logic [CNT_W-1:0] retry_ext;
  logic [CNT_W:0]   cnt_plus;
  logic [CNT_W:0]   blank_wide;
  logic             dwell_done;
  logic             blank_done;
  logic             unused_supply;

  assign unused_supply = CELV ^ CELG ^ SUB;

  assign dead_eff   = (dead == '0) ? CNT_W'(1) : CNT_W'(dead);
  assign retry_ext  = CNT_W'(retry);
  assign dwell_done = (cnt == (len - CNT_W'(1)));

  // cnt_plus is the number of HS_ON cycles completed at the sampling edge
  assign cnt_plus   = {1'b0, cnt} + (CNT_W + 1)'(1);
  assign blank_wide = {1'b0, CNT_W'(blank)};
  assign blank_done = (cnt_plus >= blank_wide);

  always_comb begin
    nxt = cur;
    if (!en) begin
      nxt = S_OFF;
    end else begin
      case (cur)
        S_OFF:      nxt = S_DT_TO_LS;
        S_DT_TO_HS: if (dwell_done) nxt = S_HS_ON;
        S_DT_TO_LS: if (dwell_done) nxt = S_LS_ON;
        S_HS_ON: begin
          if (blank_done && ocp) nxt = S_FAULT;
          else if (!pwm)         nxt = S_DT_TO_LS;
        end
        S_LS_ON:    if (pwm) nxt = S_DT_TO_HS;
        // a zero retry length latches the fault until en drops
        S_FAULT:    if ((len != '0) && dwell_done) nxt = S_OFF;
        default:    nxt = S_OFF;
      endcase
    end
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      cur <= S_OFF;
    end else begin
      cur <= nxt;
    end
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      cnt       <= '0;
      len       <= '0;
      fault_cnt <= 8'd0;
      hs        <= 1'b0;
      ls        <= 1'b0;
      fault     <= 1'b0;
    end else begin
      if (nxt != cur) begin
        cnt <= '0;
        if ((nxt == S_DT_TO_HS) || (nxt == S_DT_TO_LS)) begin
          len <= dead_eff;
        end else if (nxt == S_FAULT) begin
          len <= retry_ext;
        end
      end else if (cnt != '1) begin
        cnt <= cnt + CNT_W'(1);
      end
      if ((nxt == S_FAULT) && (cur != S_FAULT) && (fault_cnt != 8'hFF)) begin
        fault_cnt <= fault_cnt + 8'd1;
      end
      hs    <= (nxt == S_HS_ON);
      ls    <= (nxt == S_LS_ON);
      fault <= (nxt == S_FAULT);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_stepdown_gate_seq.sv
// Scoreboard bench for stepdown_gate_seq: directed vectors push the expected
// post-edge state, a monitor pops and compares one entry per clock.
module tb_stepdown_gate_seq;

  logic       CELCLK = 1'b0;
  logic       CELRSTN;
  logic       CELV = 1'b1;
  logic       CELG = 1'b0;
  logic       SUB  = 1'b0;
  logic       en;
  logic       pwm;
  logic       ocp;
  logic [3:0] dead;
  logic [3:0] blank;
  logic [7:0] retry;
  logic       hs;
  logic       ls;
  logic       fault;
  logic [2:0] state;
  logic [7:0] fault_cnt;

  typedef struct {
    logic [2:0] st;
    logic [7:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   error_count = 0;
  int   check_count = 0;

  stepdown_gate_seq #(.DEAD_W(4), .BLANK_W(4), .RETRY_W(8)) dut (
    .CELCLK    (CELCLK),
    .CELRSTN   (CELRSTN),
    .CELV      (CELV),
    .CELG      (CELG),
    .SUB       (SUB),
    .en        (en),
    .pwm       (pwm),
    .ocp       (ocp),
    .dead      (dead),
    .blank     (blank),
    .retry     (retry),
    .hs        (hs),
    .ls        (ls),
    .fault     (fault),
    .state     (state),
    .fault_cnt (fault_cnt)
  );

  initial forever #5 CELCLK = ~CELCLK;

  task automatic check_value(input string name, input int got, input int want);
    check_count++;
    if (got != want) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // gate and fault levels follow directly from the expected state code
  task automatic check_output(input exp_t e);
    check_value("state", int'(state), int'(e.st));
    check_value("hs", int'(hs), (e.st == 3'd2) ? 1 : 0);
    check_value("ls", int'(ls), (e.st == 3'd4) ? 1 : 0);
    check_value("fault", int'(fault), (e.st == 3'd5) ? 1 : 0);
    check_value("fault_cnt", int'(fault_cnt), int'(e.fc));
  endtask

  task automatic apply_stimulus(input logic s_en, input logic s_pwm, input logic s_ocp,
                                input logic [2:0] st, input logic [7:0] fc);
    exp_t e;
    @(negedge CELCLK);
    en  = s_en;
    pwm = s_pwm;
    ocp = s_ocp;
    e.st = st;
    e.fc = fc;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CELCLK);
    if (exp_q.size() > 0) begin
      check_count++;
      error_count++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_state"}, int'(state), 0);
    check_value({tag, "_hs"}, int'(hs), 0);
    check_value({tag, "_ls"}, int'(ls), 0);
    check_value({tag, "_fault"}, int'(fault), 0);
    check_value({tag, "_fault_cnt"}, int'(fault_cnt), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CELCLK);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin : stimulus
    logic [7:0] fc;
    CELRSTN = 1'b1;
    en = 1'b0; pwm = 1'b0; ocp = 1'b0;
    dead = 4'd3; blank = 4'd0; retry = 8'd0;
    #1 CELRSTN = 1'b0;
    repeat (2) @(negedge CELCLK);
    check_reset_outputs("reset");
    CELRSTN = 1'b1;
    apply_stimulus(0, 0, 0, 3'd0, 8'd0);

    // enable with dead=3: three dead-time cycles, then LS_ON
    apply_stimulus(1, 0, 0, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 3'd4, 8'd0);
    apply_stimulus(1, 0, 0, 3'd4, 8'd0);

    // dead=2 round trip; the pwm blip inside DT_TO_LS is ignored
    dead = 4'd2;
    apply_stimulus(1, 1, 0, 3'd1, 8'd0);
    apply_stimulus(1, 1, 0, 3'd1, 8'd0);
    apply_stimulus(1, 1, 0, 3'd2, 8'd0);
    apply_stimulus(1, 1, 0, 3'd2, 8'd0);
    apply_stimulus(1, 0, 0, 3'd3, 8'd0);
    apply_stimulus(1, 1, 0, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 3'd4, 8'd0);
    apply_stimulus(1, 0, 0, 3'd4, 8'd0);

    // dead=0 behaves as a single dead cycle
    dead = 4'd0;
    apply_stimulus(1, 1, 0, 3'd1, 8'd0);
    apply_stimulus(1, 1, 0, 3'd2, 8'd0);
    apply_stimulus(1, 0, 0, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 3'd4, 8'd0);

    // blank=4 with ocp held high: trip on the 4th HS_ON edge, retry after 10
    dead = 4'd1; blank = 4'd4; retry = 8'd10;
    apply_stimulus(1, 1, 1, 3'd1, 8'd0);
    apply_stimulus(1, 1, 1, 3'd2, 8'd0);
    apply_stimulus(1, 1, 1, 3'd2, 8'd0);
    apply_stimulus(1, 1, 1, 3'd2, 8'd0);
    apply_stimulus(1, 1, 1, 3'd2, 8'd0);
    apply_stimulus(1, 1, 1, 3'd5, 8'd1);
    for (int i = 0; i < 9; i++) apply_stimulus(1, 0, 0, 3'd5, 8'd1);
    apply_stimulus(1, 0, 0, 3'd0, 8'd1);
    apply_stimulus(1, 0, 0, 3'd3, 8'd1);
    apply_stimulus(1, 0, 0, 3'd4, 8'd1);

    // retry=0 latches the fault until en drops
    blank = 4'd0; retry = 8'd0;
    apply_stimulus(1, 1, 0, 3'd1, 8'd1);
    apply_stimulus(1, 1, 0, 3'd2, 8'd1);
    apply_stimulus(1, 1, 1, 3'd5, 8'd2);
    for (int i = 0; i < 500; i++) apply_stimulus(1, 0, 0, 3'd5, 8'd2);
    apply_stimulus(0, 0, 0, 3'd0, 8'd2);

    // en=0 together with ocp=1 in HS_ON: OFF wins, no count
    apply_stimulus(1, 0, 0, 3'd3, 8'd2);
    apply_stimulus(1, 0, 0, 3'd4, 8'd2);
    apply_stimulus(1, 1, 0, 3'd1, 8'd2);
    apply_stimulus(1, 1, 0, 3'd2, 8'd2);
    apply_stimulus(0, 1, 1, 3'd0, 8'd2);

    // 300 forced faults saturate the fault counter at 255
    fc = 8'd2;
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1, 0, 0, 3'd3, fc);
      apply_stimulus(1, 0, 0, 3'd4, fc);
      apply_stimulus(1, 1, 0, 3'd1, fc);
      apply_stimulus(1, 1, 0, 3'd2, fc);
      if (fc != 8'd255) fc = fc + 8'd1;
      apply_stimulus(1, 1, 1, 3'd5, fc);
      apply_stimulus(0, 0, 0, 3'd0, fc);
    end

    // asynchronous reset in the middle of DT_TO_HS
    apply_stimulus(1, 0, 0, 3'd3, 8'd255);
    apply_stimulus(1, 0, 0, 3'd4, 8'd255);
    dead = 4'd5;
    apply_stimulus(1, 1, 0, 3'd1, 8'd255);
    apply_stimulus(1, 1, 0, 3'd1, 8'd255);
    drain();
    #2;
    CELRSTN = 1'b0;
    en = 1'b0;
    #1;
    check_reset_outputs("rst_mid_dt");
    @(negedge CELCLK);
    CELRSTN = 1'b1;
    apply_stimulus(0, 0, 0, 3'd0, 8'd0);
    apply_stimulus(0, 1, 0, 3'd0, 8'd0);

    // asynchronous reset in the middle of a latched FAULT
    dead = 4'd1; blank = 4'd0; retry = 8'd0;
    apply_stimulus(1, 0, 0, 3'd3, 8'd0);
    apply_stimulus(1, 0, 0, 3'd4, 8'd0);
    apply_stimulus(1, 1, 0, 3'd1, 8'd0);
    apply_stimulus(1, 1, 0, 3'd2, 8'd0);
    apply_stimulus(1, 1, 1, 3'd5, 8'd1);
    apply_stimulus(1, 0, 0, 3'd5, 8'd1);
    drain();
    #2;
    CELRSTN = 1'b0;
    en = 1'b0;
    #1;
    check_reset_outputs("rst_mid_fault");
    @(negedge CELCLK);
    CELRSTN = 1'b1;
    apply_stimulus(0, 0, 0, 3'd0, 8'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule

// File: doc/stepdown_gate_seq.md
# stepdown_gate_seq

Synchronous non-overlap gate sequencer for the stepdown core. It converts the PWM request into mutually exclusive high-side and low-side gate commands separated by a programmable dead time. It applies leading-edge blanking to the overcurrent comparator and runs a fault/auto-retry sequence. Its registered `hs`/`ls` outputs drive the core-state latch (`nor2` cross-coupled cells) from the synchronous side.

## Interface
- `DEAD_W`, 4: width of dead-time setting, in clock cycles.
- `BLANK_W`, 4: width of leading-edge blanking setting.
- `RETRY_W`, 8: width of fault retry delay setting.
- `CELCLK`  in  1  core clock; all state changes on rising edge.
- `CELRSTN`  in  1  reset, asynchronous, active-low.
- `CELV`, `CELG`, `SUB`  in  1  supply/ground/substrate pins; no logic function.
- `en`  in  1  converter enable, synchronous.
- `pwm`  in  1  PWM request: 1 = high-side on, 0 = low-side on.
- `ocp`  in  1  overcurrent comparator, already synchronized upstream.
- `dead`  in  DEAD_W  dead time in cycles; 0 is treated as 1.
- `blank`  in  BLANK_W  cycles at start of HS_ON during which `ocp` is ignored.
- `retry`  in  RETRY_W  FAULT dwell in cycles; 0 = latched until `en`=0.
- `hs`  out  1  high-side gate command, registered.
- `ls`  out  1  low-side gate command, registered.
- `fault`  out  1  high while in FAULT.
- `state`  out  3  current state: OFF=0, DT_TO_HS=1, HS_ON=2, DT_TO_LS=3, LS_ON=4, FAULT=5.
- `fault_cnt`  out  8  count of FAULT entries; saturates at 255; cleared only by reset.

## Operation
- Reset (`CELRSTN`=0, asynchronous): state=OFF; `hs`=`ls`=`fault`=0; `fault_cnt`=0; all internal counters 0.
- Priority every cycle: `en`=0 first, then OCP fault, then `pwm`.
- `en`=0 in any state forces OFF on the next edge and clears `fault`.
- `hs`, `ls` and `fault` are decoded registered from state: `hs`=1 only in HS_ON, `ls`=1 only in LS_ON, `fault`=1 only in FAULT. `hs` and `ls` are never both 1.
- OFF: `en`=1 → DT_TO_LS.
- DT_TO_HS / DT_TO_LS: both gates 0. The state lasts exactly D=max(`dead`,1) cycles, then moves to HS_ON / LS_ON. `pwm` is ignored in these states. `dead` is sampled on entry.
- HS_ON:
  - The blanking counter starts at 0 on entry. `ocp` is ignored while count < `blank`.
  - After blanking, `ocp`=1 → FAULT and `fault_cnt`+1 (saturating).
  - Otherwise `pwm`=0 → DT_TO_LS.
  - Minimum HS_ON dwell is 1 cycle.
- LS_ON: `pwm`=1 → DT_TO_HS. `ocp` is ignored.
- FAULT:
  - Both gates 0 and `fault`=1.
  - With `retry`≠0: after exactly `retry` cycles → OFF, then normal restart through DT_TO_LS if `en`=1.
  - With `retry`=0: FAULT holds until `en`=0.
  - `retry` is sampled on entry.
- Counters are width-limited and never wrap. Dead, blank and retry counters reset on every state entry.

## Timing
- `pwm` rise sampled at edge k while in LS_ON: `ls`=0 after edge k; `hs`=1 after edge k+D.
- `pwm` fall sampled at edge k while in HS_ON: `hs`=0 after edge k; `ls`=1 after edge k+D.
- `en` rise sampled at edge k from OFF: `ls`=1 after edge k+D.
- OCP trip: `ocp` sampled high at edge k, with at least `blank` full cycles already spent in HS_ON, gives `hs`=0 and `fault`=1 after edge k.
- A `pwm` toggle during a dead-time state is ignored. The level seen in the destination ON state decides the next move. Pulses shorter than D+1 cycles may be absorbed.
- Simultaneous `en`=0 and `ocp`=1: OFF wins; `fault_cnt` is not incremented.
- Reset asserted mid-dead-time or mid-FAULT: outputs go to 0 immediately (asynchronous). After deassertion the block waits in OFF for `en`.

## Test plan
- Reset, then `en`=1, `pwm`=0, `dead`=3 → `ls` rises 3 cycles after `en` is sampled; `state` reads 3 then 4.
- In LS_ON, `pwm` 0→1 with `dead`=2 → `ls` falls next edge; `hs` rises 2 edges later; `hs`&`ls` never both 1 over 1000 random `pwm` cycles.
- `dead`=0 → exactly 1 cycle with both gates low on each transition.
- `blank`=4, `ocp`=1 from the first HS_ON cycle → FAULT entered after the 4th HS_ON cycle; `fault_cnt`=1; with `retry`=10, OFF after 10 cycles and `ls` restarts.
- `retry`=0 fault → FAULT held for 500 cycles; `en`=0 → OFF next edge, `fault`=0; 300 forced faults → `fault_cnt`=255.
- `CELRSTN` pulsed low mid-DT_TO_HS → `hs`/`ls`/`state` equal 0 immediately, with no clock edge.
